// File: rtl/cargador_pkg.sv
// Shared definitions for the boot-time program loader: stream framing sizes
// and the loader FSM state encoding.
package cargador_pkg;
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int INSTR_W    = 32;

    typedef enum logic [2:0] {
        S_LEN_LO = 3'd0,
        S_LEN_HI = 3'd1,
        S_DATA   = 3'd2,
        S_CHK    = 3'd3,
        S_DONE   = 3'd4,
        S_ERR    = 3'd5
    } estado_t;
endpackage

// File: rtl/cargador_programa_ensamblador.sv
// Byte-to-word assembler: inserts little-endian bytes into a 32-bit word and
// flags the byte that completes it.
module ensamblador_palabra
    import cargador_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_clear,
    input  logic               i_valid,
    input  logic [7:0]         i_byte,
    output logic [INSTR_W-1:0] o_word,
    output logic               o_complete
);
    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0]   r_idx;
    logic [INSTR_W-1:0] r_word;

    // o_word already contains the current byte so the top can register the
    // finished word on the same edge that accepts its last byte.
    always_comb begin
        o_word = r_word;
        o_word[{r_idx, 3'b000} +: 8] = i_byte;
    end

    assign o_complete = i_valid && (r_idx == IDX_W'(WORD_BYTES - 1));

    always_ff @(posedge i_clk) begin
        if (i_clear) begin
            r_idx  <= '0;
            r_word <= '0;
        end else if (i_valid) begin
            r_word <= o_word;
            r_idx  <= r_idx + 1'b1;
        end
    end
endmodule

// File: rtl/cargador_programa.sv
// Program loader: parses LEN / payload / CHK byte stream, writes instruction
// memory and holds the processor in reset until a verified image is loaded.
module cargador_programa
    import cargador_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_wdata,
    output logic               cpu_reset,
    output logic               done,
    output logic               error
);
    localparam int LEN_W = HDR_BYTES * 8;
    localparam int CNT_W = LEN_W + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << ADDR_W;

    estado_t            r_state;
    logic               r_ready;
    logic               r_we;
    logic               r_done;
    logic               r_error;
    logic [ADDR_W-1:0]  r_addr;
    logic [INSTR_W-1:0] r_wdata;
    logic [CNT_W-1:0]   r_cnt;
    logic [LEN_W-1:0]   r_len;
    logic [7:0]         r_xor;

    logic               w_accept;
    logic               w_asm_valid;
    logic               w_word_done;
    logic [INSTR_W-1:0] w_word;
    logic [CNT_W-1:0]   w_len_full;
    logic [CNT_W-1:0]   w_cnt_next;

    assign w_accept    = in_valid && r_ready;
    assign w_asm_valid = w_accept && (r_state == S_DATA);
    assign w_len_full  = {1'b0, in_data, r_len[7:0]};
    assign w_cnt_next  = r_cnt + 1'b1;

    ensamblador_palabra u_ensamblador (
        .i_clk      (clk),
        .i_clear    (reset),
        .i_valid    (w_asm_valid),
        .i_byte     (in_data),
        .o_word     (w_word),
        .o_complete (w_word_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LEN_LO;
            r_ready <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_cnt   <= '0;
            r_len   <= '0;
            r_xor   <= '0;
        end else begin
            r_we <= 1'b0;
            case (r_state)
                S_LEN_LO: begin
                    r_ready <= 1'b1;
                    if (w_accept) begin
                        r_len[7:0] <= in_data;
                        r_xor      <= r_xor ^ in_data;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_LEN_HI: if (w_accept) begin
                    r_len[15:8] <= in_data;
                    r_xor       <= r_xor ^ in_data;
                    if (w_len_full > MAX_WORDS) begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                        r_ready <= 1'b0;
                    end else if (w_len_full == '0) begin
                        r_state <= S_CHK;
                    end else begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: if (w_accept) begin
                    r_xor <= r_xor ^ in_data;
                    if (w_word_done) begin
                        r_we    <= 1'b1;
                        r_addr  <= r_cnt[ADDR_W-1:0];
                        r_wdata <= w_word;
                        r_cnt   <= w_cnt_next;
                        if (w_cnt_next == {1'b0, r_len})
                            r_state <= S_CHK;
                    end
                end
                S_CHK: if (w_accept) begin
                    r_ready <= 1'b0;
                    if (in_data == r_xor) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= S_ERR;
                        r_error <= 1'b1;
                    end
                end
                default: r_ready <= 1'b0;
            endcase
        end
    end

    assign in_ready   = r_ready;
    assign imem_we    = r_we;
    assign imem_addr  = r_addr;
    assign imem_wdata = r_wdata;
    assign done       = r_done;
    assign error      = r_error;
    assign cpu_reset  = ~r_done;
endmodule

// File: tb/tb_cargador_programa.sv
// Scoreboard bench for cargador_programa: stimulus pushes expected memory
// writes, a negedge monitor pops and compares every imem_we strobe.
module tb_cargador_programa;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              cpu_reset;
    logic              done;
    logic              error;

    cargador_programa #(.ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_reset  (cpu_reset),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  total = 0;
    int  bad = 0;
    int  gap_mode = 0;  // 0: none, 1: every other cycle, 2: random

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: addr %h data %h", imem_addr, imem_wdata);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_addr", {24'h0, imem_addr}, {24'h0, mon_e.a});
                chk("wr_data", imem_wdata, mon_e.d);
            end
        end
    end

    // Returns #1 after the edge that accepted the byte.
    task automatic send(input logic [7:0] b);
        int n = 0;
        int idle;
        idle = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
        repeat (idle) begin in_valid = 1'b0; @(posedge clk); #1; end
        in_data  = b;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready %b expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        chk("rst_in_ready", {31'h0, in_ready}, 32'h0);
        chk("rst_we", {31'h0, imem_we}, 32'h0);
        chk("rst_addr", {24'h0, imem_addr}, 32'h0);
        chk("rst_wdata", imem_wdata, 32'h0);
        chk("rst_status", {29'h0, cpu_reset, done, error}, 32'h4);
        exp_q.delete();
        reset = 1'b0;
        @(posedge clk); #1;
        chk("rst_we_after", {31'h0, imem_we}, 32'h0);
        chk("ready_after_rst", {31'h0, in_ready}, 32'h1);
    endtask

    // Reference: word i lands at address i; CHK is XOR of every earlier byte.
    task automatic load(input logic [31:0] w[$], input bit bad_chk);
        logic [7:0] x;
        logic [15:0] n;
        logic [31:0] cur;
        n = 16'(w.size());
        x = n[7:0] ^ n[15:8];
        for (int i = 0; i < w.size(); i++) exp_q.push_back('{a: ADDR_W'(i), d: w[i]});
        send(n[7:0]);
        send(n[15:8]);
        for (int i = 0; i < w.size(); i++) begin
            cur = w[i];
            for (int k = 0; k < 4; k++) begin
                x = x ^ cur[k*8 +: 8];
                send(cur[k*8 +: 8]);
            end
        end
        send(bad_chk ? (x ^ 8'h01) : x);
        chk("done", {31'h0, done}, {31'h0, !bad_chk});
        chk("error", {31'h0, error}, {31'h0, bad_chk});
        chk("cpu_reset", {31'h0, cpu_reset}, {31'h0, bad_chk});
        chk("ready_final", {31'h0, in_ready}, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("writes_drained", exp_q.size(), 32'h0);
    endtask

    logic [31:0] words[$];

    initial begin
        do_reset();

        // Three-word program, good checksum.
        words = '{32'h20080005, 32'h20090007, 32'h01095020};
        load(words, 1'b0);

        // Same program, corrupted checksum; later bytes must be ignored.
        do_reset();
        load(words, 1'b1);
        in_valid = 1'b1;
        repeat (5) begin in_data = 8'($urandom); @(posedge clk); #1; end
        in_valid = 1'b0;
        chk("err_sticky", {30'h0, error, in_ready}, 32'h2);

        // Oversize length: error right after LEN_HI, no writes.
        do_reset();
        send(8'h01);
        send(8'h01);
        chk("len_err", {29'h0, error, done, in_ready}, 32'h4);
        chk("len_err_cpu_reset", {31'h0, cpu_reset}, 32'h1);

        // Full-capacity image.
        do_reset();
        words.delete();
        for (int i = 0; i < 256; i++) words.push_back($urandom);
        load(words, 1'b0);

        // Empty image.
        do_reset();
        words.delete();
        load(words, 1'b0);

        // One word with in_valid toggling.
        do_reset();
        gap_mode = 1;
        words = '{32'hA5C3_0F96};
        load(words, 1'b0);
        gap_mode = 0;

        // Reset after six bytes; word 0 is written just before reset lands.
        do_reset();
        words = '{32'h11223344, 32'h55667788};
        exp_q.push_back('{a: 0, d: words[0]});
        send(8'h02); send(8'h00);
        send(8'h44); send(8'h33); send(8'h22); send(8'h11);
        chk("mid_we", {31'h0, imem_we}, 32'h1);
        @(negedge clk);
        do_reset();
        @(posedge clk); #1;
        chk("mid_we_idle", {31'h0, imem_we}, 32'h0);
        words = '{32'hDEADBEEF, 32'h0BADF00D};
        load(words, 1'b0);

        // Randomized images with random gaps and checksum corruption.
        for (int it = 0; it < 6; it++) begin
            do_reset();
            gap_mode = 2;
            words.delete();
            for (int i = 0; i < int'($urandom_range(1, 6)); i++) words.push_back($urandom);
            load(words, 1'($urandom_range(0, 1)));
        end
        gap_mode = 0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
